// File: rtl/pc_ctrl.sv
// Program-counter unit for the IF stage: fetch address, instruction-memory enable,
// sequential advance, and redirects from branch, exception and exception return.
module pc_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STEP      = 4,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned EXC_VEC   = 32'h0000_0020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              exc_flag,
    input  logic              eret_flag,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending,
    output logic              misalign_err
);

    localparam logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] EXC_PC    = ADDR_W'(EXC_VEC);
    localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);

    typedef enum logic {
        OFF,
        RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic              pending;
    logic              pending_next;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] pend_addr_next;
    logic              err_q;
    logic              err_next;
    logic              adv;

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return (addr & STEP_MASK) != '0;
    endfunction

    assign adv = (state == RUN) & ~stall & fetch_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OFF;
            pc_q      <= RESET_PC;
            pending   <= 1'b0;
            pend_addr <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            pending   <= pending_next;
            pend_addr <= pend_addr_next;
            err_q     <= err_next;
        end
    end

    // Redirect priority: exception > eret > branch (unstalled) > branch capture
    // under stall > pending replay > sequential advance. A misaligned target is
    // dropped, flags an error, and discards any pending branch.
    always_comb begin
        state_next     = state;
        pc_next        = pc_q;
        pending_next   = pending;
        pend_addr_next = pend_addr;
        err_next       = 1'b0;

        unique case (state)
            OFF: begin
                state_next = RUN;
                pc_next    = RESET_PC;
            end
            RUN: begin
                if (exc_flag) begin
                    pc_next      = EXC_PC;
                    pending_next = 1'b0;
                end else if (eret_flag) begin
                    if (misaligned(epc)) begin
                        err_next     = 1'b1;
                        pending_next = 1'b0;
                    end else begin
                        pc_next = epc;
                    end
                end else if (branch_flag && !stall) begin
                    pending_next = 1'b0;
                    if (misaligned(branch_target)) begin
                        err_next = 1'b1;
                    end else begin
                        pc_next = branch_target;
                    end
                end else if (branch_flag && stall) begin
                    pending_next   = 1'b1;
                    pend_addr_next = branch_target;
                end else if (pending && !stall) begin
                    pending_next = 1'b0;
                    if (misaligned(pend_addr)) begin
                        err_next = 1'b1;
                    end else begin
                        pc_next = pend_addr;
                    end
                end else if (adv) begin
                    pc_next = pc_q + STEP_INC;
                end
            end
            default: begin
                state_next = OFF;
                pc_next    = RESET_PC;
            end
        endcase
    end

    assign pc               = pc_q;
    assign ce               = (state == RUN);
    assign redirect_pending = pending;
    assign misalign_err     = err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a stimulus process queues hand-computed post-edge
// expectations, and a monitor pops and compares them after every rising edge.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        exc_flag = 1'b0;
    logic        eret_flag = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pending;
    logic        misalign_err;

    logic        rst8 = 1'b1;
    logic        fetch_ready8 = 1'b0;
    logic        branch_flag8 = 1'b0;
    logic [7:0]  branch_target8 = '0;
    logic [7:0]  pc8;
    logic        ce8;
    logic        pend8;
    logic        err8;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_ctrl #(.ADDR_W(32), .STEP(4), .RESET_VEC(0), .EXC_VEC(32'h20)) dut (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .exc_flag(exc_flag), .eret_flag(eret_flag), .epc(epc),
        .pc(pc), .ce(ce), .redirect_pending(redirect_pending), .misalign_err(misalign_err)
    );

    pc_ctrl #(.ADDR_W(8), .STEP(4), .RESET_VEC(0), .EXC_VEC(32'h20)) dut8 (
        .clk(clk), .rst(rst8), .stall(1'b0), .fetch_ready(fetch_ready8),
        .branch_flag(branch_flag8), .branch_target(branch_target8),
        .exc_flag(1'b0), .eret_flag(1'b0), .epc(8'h00),
        .pc(pc8), .ce(ce8), .redirect_pending(pend8), .misalign_err(err8)
    );

    task automatic compare(input exp_t e, input logic [31:0] a_pc, input logic a_ce,
                           input logic a_pend, input logic a_err);
        checks++;
        if (a_pc !== e.pc || a_ce !== e.ce || a_pend !== e.pend || a_err !== e.err) begin
            errors++;
            $display("FAIL %s: got pc=%h ce=%b pend=%b err=%b, want pc=%h ce=%b pend=%b err=%b",
                     e.tag, a_pc, a_ce, a_pend, a_err, e.pc, e.ce, e.pend, e.err);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare(e, pc, ce, redirect_pending, misalign_err);
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                compare(e, {24'h0, pc8}, ce8, pend8, err8);
            end
        end
    end

    // Drive one cycle of inputs on the falling edge and queue the state expected after the next rising edge.
    task automatic cyc(input string tag, input logic r, input logic s, input logic fr,
                       input logic br, input logic [31:0] bt, input logic ex,
                       input logic er, input logic [31:0] ep,
                       input logic [31:0] x_pc, input logic x_ce, input logic x_pend,
                       input logic x_err);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; fetch_ready = fr; branch_flag = br; branch_target = bt;
        exc_flag = ex; eret_flag = er; epc = ep;
        e.tag = tag; e.pc = x_pc; e.ce = x_ce; e.pend = x_pend; e.err = x_err;
        q.push_back(e);
    endtask

    task automatic cyc8(input string tag, input logic r, input logic fr, input logic br,
                        input logic [7:0] bt, input logic [31:0] x_pc, input logic x_ce);
        exp_t e;
        @(negedge clk);
        rst8 = r; fetch_ready8 = fr; branch_flag8 = br; branch_target8 = bt;
        e.tag = tag; e.pc = x_pc; e.ce = x_ce; e.pend = 1'b0; e.err = 1'b0;
        q8.push_back(e);
    endtask

    initial begin
        //   tag          rst st fr br target   ex er epc       pc      ce pend err
        for (int i = 0; i < 3; i++)
            cyc("reset",     1, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h0,   0, 0, 0);
        cyc("start",       0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h0,   1, 0, 0);
        cyc("adv4",        0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h4,   1, 0, 0);
        cyc("adv8",        0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h8,   1, 0, 0);
        cyc("advC",        0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'hC,   1, 0, 0);
        cyc("adv10",       0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h10,  1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("notready",  0, 0, 0, 0, 32'h0,   0, 0, 32'h0,  32'h10,  1, 0, 0);
        cyc("ready14",     0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h14,  1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("stallhold", 0, 1, 1, 0, 32'h0,   0, 0, 32'h0,  32'h14,  1, 0, 0);
        cyc("unstall18",   0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h18,  1, 0, 0);
        cyc("adv1C",       0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h1C,  1, 0, 0);
        cyc("adv20",       0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h20,  1, 0, 0);
        cyc("brstall100",  0, 1, 1, 1, 32'h100, 0, 0, 32'h0,  32'h20,  1, 1, 0);
        cyc("pendhold",    0, 1, 1, 0, 32'h0,   0, 0, 32'h0,  32'h20,  1, 1, 0);
        cyc("brstall200",  0, 1, 1, 1, 32'h200, 0, 0, 32'h0,  32'h20,  1, 1, 0);
        cyc("pendapply",   0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h200, 1, 0, 0);
        cyc("brstall300",  0, 1, 1, 1, 32'h300, 0, 0, 32'h0,  32'h200, 1, 1, 0);
        cyc("pendnordy",   0, 0, 0, 0, 32'h0,   0, 0, 32'h0,  32'h300, 1, 0, 0);
        cyc("brstall180",  0, 1, 1, 1, 32'h180, 0, 0, 32'h0,  32'h300, 1, 1, 0);
        cyc("prio_exc",    0, 1, 0, 1, 32'h80,  1, 1, 32'h40, 32'h20,  1, 0, 0);
        cyc("eret44",      0, 0, 1, 0, 32'h0,   0, 1, 32'h44, 32'h44,  1, 0, 0);
        cyc("adv48",       0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h48,  1, 0, 0);
        cyc("brnordy104",  0, 0, 0, 1, 32'h104, 0, 0, 32'h0,  32'h104, 1, 0, 0);
        cyc("mis_br",      0, 0, 1, 1, 32'h102, 0, 0, 32'h0,  32'h104, 1, 0, 1);
        cyc("mis_clear",   0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h108, 1, 0, 0);
        cyc("mis_eret",    0, 0, 1, 0, 32'h0,   0, 1, 32'h46, 32'h108, 1, 0, 1);
        cyc("mis_eret_cl", 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,  32'h108, 1, 0, 0);
        cyc("brstall1F1",  0, 1, 1, 1, 32'h1F1, 0, 0, 32'h0,  32'h108, 1, 1, 0);
        cyc("mis_pend",    0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h108, 1, 0, 1);
        cyc("mis_pend_cl", 0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h10C, 1, 0, 0);
        cyc("brheld1",     0, 0, 1, 1, 32'h400, 0, 0, 32'h0,  32'h400, 1, 0, 0);
        cyc("brheld2",     0, 0, 1, 1, 32'h400, 0, 0, 32'h0,  32'h400, 1, 0, 0);
        cyc("adv404",      0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h404, 1, 0, 0);
        cyc("excstall",    0, 1, 0, 0, 32'h0,   1, 0, 32'h0,  32'h20,  1, 0, 0);
        cyc("br300",       0, 0, 1, 1, 32'h300, 0, 0, 32'h0,  32'h300, 1, 0, 0);
        cyc("brstall500",  0, 1, 1, 1, 32'h500, 0, 0, 32'h0,  32'h300, 1, 1, 0);
        cyc("rstmid",      1, 1, 1, 1, 32'h600, 1, 0, 32'h0,  32'h0,   0, 0, 0);
        cyc("restart",     0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h0,   1, 0, 0);
        cyc("readv4",      0, 0, 1, 0, 32'h0,   0, 0, 32'h0,  32'h4,   1, 0, 0);

        cyc8("w8_reset",   1, 1, 0, 8'h00, 32'h0,  0);
        cyc8("w8_reset",   1, 1, 0, 8'h00, 32'h0,  0);
        cyc8("w8_start",   0, 1, 0, 8'h00, 32'h0,  1);
        cyc8("w8_brFC",    0, 0, 1, 8'hFC, 32'hFC, 1);
        cyc8("w8_wrap",    0, 1, 0, 8'h00, 32'h0,  1);
        cyc8("w8_adv4",    0, 1, 0, 8'h00, 32'h4,  1);

        for (int i = 0; i < 20 && (q.size() > 0 || q8.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        if (q.size() > 0 || q8.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d expectations left, want 0", q.size() + q8.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter unit for the IF stage. It generates the instruction fetch address and the instruction-memory chip enable, and advances the PC by a fixed step when the fetch is accepted. It takes redirects from branch/jump resolution, exceptions and exception return, and holds under pipeline stall or memory back-pressure. A branch that arrives during a stall is latched and applied later, so no branch is lost. It drives the instruction-ROM address/enable and the IF/ID register.

## Interface
- ADDR_W, 32, PC / address width in bits
- STEP, 4, byte increment per sequential fetch; must be a power of two ≥ 1
- RESET_VEC, 0, PC value held during and immediately after reset
- EXC_VEC, 32'h0000_0020, exception handler entry address (truncated to ADDR_W)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline stall from control unit; freezes PC
- fetch_ready  in  1  instruction memory accepts the current address this cycle
- branch_flag  in  1  branch/jump taken, one-cycle pulse
- branch_target  in  ADDR_W  redirect address, valid with branch_flag
- exc_flag  in  1  exception taken, one-cycle pulse
- eret_flag  in  1  exception return, one-cycle pulse
- epc  in  ADDR_W  return address, valid with eret_flag
- pc  out  ADDR_W  current fetch address (registered)
- ce  out  1  instruction-memory chip enable (registered)
- redirect_pending  out  1  latched branch awaiting stall release
- misalign_err  out  1  one-cycle pulse: rejected misaligned redirect target

## Operation
- Two states:
  - OFF: ce=0. This is the state during rst and for the first edge after it.
  - RUN: ce=1.
  - OFF→RUN on the first posedge with rst=0. RUN→OFF only on rst.
- `adv = ce & ~stall & fetch_ready`.
- Next-PC priority in RUN, highest first:
  1. exc_flag → pc ≤ EXC_VEC; clear pending. Applies regardless of stall or fetch_ready.
  2. eret_flag → pc ≤ epc. Applies regardless of stall or fetch_ready.
  3. branch_flag & ~stall → pc ≤ branch_target. Applies regardless of fetch_ready; clears pending.
  4. branch_flag & stall → pending ≤ 1, pend_addr ≤ branch_target; pc held. A later branch overwrites the pending entry.
  5. pending & ~stall → pc ≤ pend_addr; pending ≤ 0.
  6. adv → pc ≤ pc + STEP, modulo 2^ADDR_W (wraps silently to 0).
  7. Otherwise pc holds.
- Misaligned redirect: any target with `target & (STEP-1) ≠ 0` from branch, eret or pending.
  - Redirect is not taken: pc holds and pending is cleared.
  - misalign_err = 1 for exactly one cycle.
  - EXC_VEC is not checked.
- In OFF: pc ≤ RESET_VEC; all flags are ignored.
- redirect_pending mirrors the internal pending bit.

## Timing
- Reset values: pc = RESET_VEC, ce = 0, redirect_pending = 0, misalign_err = 0. pend_addr = 0 (internal).
- rst deasserted before edge N: ce = 1 after edge N, pc still RESET_VEC. If adv holds at edge N+1, pc = RESET_VEC + STEP after edge N+1.
- Redirect latency: the flag is sampled at edge k; the new pc is visible after edge k. There are no bubbles inside the block.
- Pending branch: applied at the first edge with stall = 0, even if fetch_ready = 0.
- rst asserted mid-operation (including with pending set or a flag high): at the next edge all state returns to reset values; rst dominates everything.
- exc_flag and eret_flag together: exception wins, eret is dropped.
- Flags are single-cycle pulses. A flag held high re-applies every cycle and does not advance the PC.

## Test plan
- Reset/start (defaults): rst high 3 cycles then low, stall = 0, fetch_ready = 1. Expect ce 0 → 1 one edge after release, pc sequence 0, 0, 4, 8, 0xC.
- Back-pressure: fetch_ready = 0 for 3 cycles at pc = 0x10. Expect pc held at 0x10, then 0x14 on the first ready edge. Same result with stall = 1 for 3 cycles.
- Branch during stall: stall = 1, branch_flag pulse with target 0x100 at pc = 0x20. Expect pc held at 0x20 and redirect_pending = 1. Then a second branch to 0x200 while still stalled. On stall release, expect pc = 0x200 and pending = 0.
- Priority: exc_flag + eret_flag (epc 0x40) + branch_flag (0x80) in the same cycle with pending set. Expect pc = 0x20 and pending cleared. Next, eret alone with epc 0x44 → pc 0x44.
- Misalignment and wrap:
  - Branch to 0x102 → pc held, misalign_err high for exactly 1 cycle.
  - ADDR_W = 8, pc = 0xFC, advance → pc = 0x00.
- Reset mid-run: rst asserted while pending = 1 at pc = 0x300. Expect pc = RESET_VEC, ce = 0, pending = 0 at the next edge.
